// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode, state and flag types for the sequenced ALU
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_SLT  = 4'd8,
    OP_SLTU = 4'd9,
    OP_MUL  = 4'd10
  } alu_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } alu_state_e;

  typedef struct packed {
    logic zero;
    logic carry;
    logic ovf;
    logic ill;
  } alu_flags_t;

endpackage

// File: rtl/alu_mul_iter.sv
// rtl/alu_mul_iter.sv - iterative shift-add multiplier, one partial product per cycle
module alu_mul_iter #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] product
);

  localparam int CW = $clog2(XLEN);

  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] mplier;
  logic [XLEN-1:0] acc;
  logic [CW-1:0]   cnt;
  logic            busy;

  // product is the accumulator after this cycle's step, so the final value is usable on the done edge
  assign product = mplier[0] ? (acc + mcand) : acc;
  assign done    = busy && (cnt == CW'(XLEN - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      busy   <= 1'b0;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= '0;
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
    end else if (busy) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (done) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked ALU with single-cycle ops and an iterative multiply
module alu_seq
  import alu_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter bit MUL_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            flag_zero,
  output logic            flag_carry,
  output logic            flag_ovf,
  output logic            flag_ill
);

  localparam int SW = $clog2(XLEN);

  alu_state_e      state;
  alu_flags_t      flags;
  alu_op_e         opc;
  logic            accept;
  logic            is_mul;
  logic            is_sub;
  logic [SW-1:0]   shamt;
  logic [XLEN-1:0] b_eff;
  logic [XLEN:0]   sum;
  logic [XLEN-1:0] comb_res;
  alu_flags_t      comb_flags;
  logic            mul_done;
  logic [XLEN-1:0] mul_product;

  assign opc      = alu_op_e'(op);
  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign is_mul   = MUL_EN && (opc == OP_MUL);
  assign is_sub   = (opc == OP_SUB);
  assign shamt    = b[SW-1:0];

  // SUB is a + ~b + 1, so carry-out means "no borrow"
  assign b_eff = is_sub ? ~b : b;
  assign sum   = {1'b0, a} + {1'b0, b_eff} + {{XLEN{1'b0}}, is_sub};

  always_comb begin
    comb_res   = '0;
    comb_flags = '0;
    case (opc)
      OP_ADD, OP_SUB: begin
        comb_res         = sum[XLEN-1:0];
        comb_flags.carry = sum[XLEN];
        comb_flags.ovf   = (a[XLEN-1] == b_eff[XLEN-1]) && (sum[XLEN-1] != a[XLEN-1]);
      end
      OP_AND:  comb_res = a & b;
      OP_OR:   comb_res = a | b;
      OP_XOR:  comb_res = a ^ b;
      OP_SLL:  comb_res = a << shamt;
      OP_SRL:  comb_res = a >> shamt;
      OP_SRA:  comb_res = $signed(a) >>> shamt;
      OP_SLT:  comb_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: comb_res = {{(XLEN-1){1'b0}}, (a < b)};
      OP_MUL:  comb_flags.ill = !MUL_EN;
      default: comb_flags.ill = 1'b1;
    endcase
    comb_flags.zero = (comb_res == '0);
  end

  alu_mul_iter #(
    .XLEN (XLEN)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (accept && is_mul),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_product)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
          end
          if (accept) begin
            if (is_mul) begin
              state     <= MUL;
              out_valid <= 1'b0;
            end else begin
              result    <= comb_res;
              flags     <= comb_flags;
              out_valid <= 1'b1;
            end
          end
        end
        MUL: begin
          if (mul_done) begin
            result    <= mul_product;
            flags     <= '{zero: (mul_product == '0), carry: 1'b0, ovf: 1'b0, ill: 1'b0};
            out_valid <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign flag_zero  = flags.zero;
  assign flag_carry = flags.carry;
  assign flag_ovf   = flags.ovf;
  assign flag_ill   = flags.ill;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq against a behavioural model
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [3:0]  op = 4'd0;
  logic [63:0] a = '0;
  logic [63:0] b = '0;

  logic        in_ready, out_valid, flag_zero, flag_carry, flag_ovf, flag_ill;
  logic [63:0] result;
  logic        n_in_ready, n_out_valid, n_zero, n_carry, n_ovf, n_ill;
  logic [63:0] n_result;

  alu_seq #(.XLEN(64), .MUL_EN(1'b1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .flag_zero(flag_zero), .flag_carry(flag_carry), .flag_ovf(flag_ovf), .flag_ill(flag_ill)
  );

  alu_seq #(.XLEN(64), .MUL_EN(1'b0)) u_nomul (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(n_in_ready), .op(op), .a(a), .b(b),
    .out_valid(n_out_valid), .out_ready(out_ready), .result(n_result),
    .flag_zero(n_zero), .flag_carry(n_carry), .flag_ovf(n_ovf), .flag_ill(n_ill)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  typedef struct {
    logic [63:0] res;
    logic [3:0]  fl;      // {zero, carry, ovf, ill}
    int unsigned acc_edge;
    int unsigned d;
  } exp_t;

  exp_t q[$];

  function automatic exp_t model(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y,
                                 input int unsigned e);
    exp_t r;
    logic signed [64:0] sr;
    logic c, v, il;
    c = 1'b0; v = 1'b0; il = 1'b0;
    r.res = '0; r.d = 0; r.acc_edge = e;
    case (o)
      4'd0: begin
        r.res = x + y;
        c = ({1'b0, x} + {1'b0, y}) > 65'h0_FFFF_FFFF_FFFF_FFFF;
        sr = $signed({x[63], x}) + $signed({y[63], y});
        v = (sr != $signed({r.res[63], r.res}));
      end
      4'd1: begin
        r.res = x - y;
        c = (x >= y);
        sr = $signed({x[63], x}) - $signed({y[63], y});
        v = (sr != $signed({r.res[63], r.res}));
      end
      4'd2: r.res = x & y;
      4'd3: r.res = x | y;
      4'd4: r.res = x ^ y;
      4'd5: r.res = x << y[5:0];
      4'd6: r.res = x >> y[5:0];
      4'd7: r.res = $signed(x) >>> y[5:0];
      4'd8: r.res = ($signed(x) < $signed(y)) ? 64'd1 : 64'd0;
      4'd9: r.res = (x < y) ? 64'd1 : 64'd0;
      4'd10: begin r.res = x * y; r.d = 64; end
      default: il = 1'b1;
    endcase
    r.fl = {(r.res == 64'd0), c, v, il};
    return r;
  endfunction

  logic prev_rst = 1'b0;
  logic exp_valid, exp_ready;

  always @(negedge clk) begin
    if (cyc > 0) begin
      exp_valid = (q.size() > 0) && (cyc >= q[0].acc_edge + q[0].d);
      exp_ready = !((q.size() > 0) && !exp_valid) && (!exp_valid || out_ready);
      chk("m_out_valid", out_valid, exp_valid);
      chk("m_in_ready", in_ready, exp_ready);
      if (exp_valid) begin
        chk("m_result", result, q[0].res);
        chk("m_flags", {flag_zero, flag_carry, flag_ovf, flag_ill}, q[0].fl);
      end
      if (prev_rst) begin
        chk("m_reset_result", result, 64'd0);
        chk("m_reset_flags", {flag_zero, flag_carry, flag_ovf, flag_ill}, 4'd0);
      end
      if (rst) begin
        q.delete();
        prev_rst = 1'b1;
      end else begin
        prev_rst = 1'b0;
        if (exp_valid && out_ready) void'(q.pop_front());
        if (in_valid && exp_ready) q.push_back(model(op, a, b, cyc + 1));
      end
    end
  end

  task automatic send(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    op = o; a = x; b = y; in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("send_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      n++;
      if (out_valid) return;
    end
    chk("wait_out_timeout", 64'd0, 64'd1);
  endtask

  function automatic logic [63:0] rnd64();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return 64'hFFFF_FFFF_FFFF_FFFF;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'h7FFF_FFFF_FFFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    int n;
    logic [63:0] saved_r;
    logic [3:0]  saved_f;
    bit taken;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_result", result, 0);

    send(4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1); wait_out(n);
    chk("add_latency", n, 1);
    chk("add_result", result, 64'd0);
    chk("add_flags", {flag_zero, flag_carry, flag_ovf, flag_ill}, 4'b1100);

    send(4'd1, 64'h8000_0000_0000_0000, 64'd1); wait_out(n);
    chk("sub_result", result, 64'h7FFF_FFFF_FFFF_FFFF);
    chk("sub_flags", {flag_zero, flag_carry, flag_ovf, flag_ill}, 4'b0110);

    send(4'd8, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0); wait_out(n);
    chk("slt_result", result, 64'd1);
    send(4'd9, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0); wait_out(n);
    chk("sltu_result", result, 64'd0);
    send(4'd7, 64'h8000_0000_0000_0000, 64'd68); wait_out(n);
    chk("sra_result", result, 64'hF800_0000_0000_0000);
    send(4'd5, 64'd1, 64'd63); wait_out(n);
    chk("sll_result", result, 64'h8000_0000_0000_0000);
    send(4'd6, 64'h1234, 64'd64); wait_out(n);
    chk("srl_shift0", result, 64'h1234);

    send(4'd10, 64'd12345, 64'd6789);
    n = 0; taken = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (out_valid) begin taken = 1'b1; break; end
      if (!in_ready) n++;
    end
    chk("mul_done_seen", taken, 1);
    chk("mul_busy_cycles", n, 64);
    chk("mul_result", result, 64'd83810205);

    send(4'd10, 64'd999, 64'd777);
    repeat (20) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("mul_abort_out_valid", out_valid, 0);
    chk("mul_abort_in_ready", in_ready, 1);
    send(4'd0, 64'd3, 64'd4); wait_out(n);
    chk("after_abort_add", result, 64'd7);

    @(posedge clk); #1 out_ready = 1'b0;
    send(4'd2, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00); wait_out(n);
    chk("and_result", result, 64'hF000_F000_F000_F000);
    saved_r = result;
    saved_f = {flag_zero, flag_carry, flag_ovf, flag_ill};
    @(posedge clk); #1;
    op = 4'd4; a = 64'h1234_5678_9ABC_DEF0; b = 64'hFFFF_0000_FFFF_0000; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_result", result, saved_r);
      chk("hold_flags", {flag_zero, flag_carry, flag_ovf, flag_ill}, saved_f);
      chk("hold_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("drain_accept_ready", in_ready, 1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("xor_no_bubble", out_valid, 1);
    chk("xor_result", result, 64'hEDCB_5678_6543_DEF0);

    send(4'hC, 64'd55, 64'd66); wait_out(n);
    chk("ill_latency", n, 1);
    chk("ill_result", result, 64'd0);
    chk("ill_flags", {flag_zero, flag_carry, flag_ovf, flag_ill}, 4'b1001);

    // randomized traffic with random backpressure; the monitor model does the checking
    @(posedge clk); #1;
    taken = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      if (!in_valid || taken) begin
        op = 4'($urandom_range(0, 15));
        a = rnd64();
        b = rnd64();
        in_valid = ($urandom_range(0, 3) != 0);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      taken = in_valid && in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (80) @(posedge clk);

    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    send(4'd10, 64'd5, 64'd7);
    @(negedge clk);
    chk("nomul_out_valid", n_out_valid, 1);
    chk("nomul_result", n_result, 64'd0);
    chk("nomul_flags", {n_zero, n_carry, n_ovf, n_ill}, 4'b1001);
    wait_out(n);
    chk("mul_small_result", result, 64'd35);
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
